// File: rtl/resample_codes_pkg.sv
// Shared resample codes: chroma formats, FSM states, vertical weights, position codes.
package resample_codes;

    // Chroma subsampling of an input beat; both 1x codes mean full-rate chroma.
    typedef enum logic [1:0] {
        FMT_420     = 2'b00,
        FMT_422     = 2'b01,
        FMT_444     = 2'b10,
        FMT_444_ALT = 2'b11
    } chroma_fmt_t;

    // Upsampler control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLEND = 2'd1,
        ST_SHIFT = 2'd2
    } ups_state_t;

    // Position codes carried alongside each beat (shared with addrgen/dta).
    localparam logic [2:0] POS_INTERIOR    = 3'd0;
    localparam logic [2:0] POS_LINE_START  = 3'd1;
    localparam logic [2:0] POS_LINE_END    = 3'd2;
    localparam logic [2:0] POS_FRAME_START = 3'd3;
    localparam logic [2:0] POS_FRAME_END   = 3'd4;

    // Upper-row weight out of 4 for a vertical phase (4:0, 3:1, 2:2, 1:3).
    function automatic logic [2:0] vphase_w_upper(input logic [1:0] vphase);
        logic [2:0] w;
        case (vphase)
            2'd0:    w = 3'd4;
            2'd1:    w = 3'd3;
            2'd2:    w = 3'd2;
            default: w = 3'd1;
        endcase
        return w;
    endfunction

    // Lower-row weight out of 4; upper + lower always sum to 4.
    function automatic logic [2:0] vphase_w_lower(input logic [1:0] vphase);
        return {1'b0, vphase};
    endfunction

endpackage

// File: rtl/resample_lane_interp.sv
// Whole-beat chroma interpolator: vertical blend (4:2:0 only), then horizontal
// doubling for 4:2:x, or pass-through for 4:4:4. Purely combinational.
module resample_lane_interp
    import resample_codes::*;
#(
    parameter int PIX_W = 8,
    parameter int LANES = 16
) (
    input  logic [1:0]             fmt,
    input  logic [1:0]             vphase,
    input  logic [LANES*PIX_W-1:0] u_upper,
    input  logic [LANES*PIX_W-1:0] u_lower,
    input  logic [LANES*PIX_W-1:0] v_upper,
    input  logic [LANES*PIX_W-1:0] v_lower,
    output logic [LANES*PIX_W-1:0] u_out,
    output logic [LANES*PIX_W-1:0] v_out
);

    localparam int HALF = LANES / 2;

    logic [2:0] w_up;
    logic [2:0] w_lo;

    // Weighted row blend; weights sum to 4 so the sum never exceeds PIX_W+2 bits.
    function automatic logic [PIX_W-1:0] vblend(input logic [PIX_W-1:0] up,
                                                input logic [PIX_W-1:0] lo,
                                                input logic [2:0]       wu,
                                                input logic [2:0]       wl);
        logic [PIX_W+1:0] acc;
        acc = (PIX_W+2)'(wu) * (PIX_W+2)'(up) + (PIX_W+2)'(wl) * (PIX_W+2)'(lo)
              + (PIX_W+2)'(2);
        return acc[PIX_W+1:2];
    endfunction

    // Rounded mean of two neighbouring chroma samples.
    function automatic logic [PIX_W-1:0] havg(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b);
        logic [PIX_W:0] s;
        s = {1'b0, a} + {1'b0, b} + (PIX_W+1)'(1);
        return s[PIX_W:1];
    endfunction

    // One chroma plane: build the column samples, then spread them over luma lanes.
    function automatic logic [LANES*PIX_W-1:0] upsample_plane(
        input logic [LANES*PIX_W-1:0] up,
        input logic [LANES*PIX_W-1:0] lo,
        input logic [1:0]             f,
        input logic [2:0]             wu,
        input logic [2:0]             wl);
        logic [PIX_W-1:0]       c [LANES];
        logic [LANES*PIX_W-1:0] res;
        for (int k = 0; k < LANES; k++) begin
            if (f == FMT_420)
                c[k] = vblend(up[k*PIX_W +: PIX_W], lo[k*PIX_W +: PIX_W], wu, wl);
            else
                c[k] = up[k*PIX_W +: PIX_W];
        end
        res = '0;
        if (f[1]) begin
            for (int k = 0; k < LANES; k++)
                res[k*PIX_W +: PIX_W] = c[k];
        end else begin
            for (int i = 0; i < HALF; i++) begin
                res[(2*i)*PIX_W +: PIX_W] = c[i];
                // The last odd lane has no right neighbour and replicates.
                if (i == HALF - 1)
                    res[(2*i+1)*PIX_W +: PIX_W] = c[i];
                else
                    res[(2*i+1)*PIX_W +: PIX_W] = havg(c[i], c[i+1]);
            end
        end
        return res;
    endfunction

    // Interpolate both chroma planes from the latched beat.
    always_comb begin
        w_up  = vphase_w_upper(vphase);
        w_lo  = vphase_w_lower(vphase);
        u_out = upsample_plane(u_upper, u_lower, fmt, w_up, w_lo);
        v_out = upsample_plane(v_upper, v_lower, fmt, w_up, w_lo);
    end

endmodule

// File: rtl/resample_upsample_n.sv
// Chroma upsampler: latches one beat of LANES luma pixels with chroma rows,
// blends chroma in one cycle, then emits one 4:4:4 pixel per cycle into the
// pixel fifo, pausing while the fifo reports almost-full.
//
// Handshake: a beat transfers on a rising clk edge where in_valid & in_ready;
// in_valid must hold its beat stable until then. in_ready never depends on
// in_valid. Output side has no ready: pixel_wr_en is a one-cycle write strobe
// that is withheld while pixel_wr_almost_full is high.
module resample_upsample_n
    import resample_codes::*;
#(
    parameter int PIX_W = 8,
    parameter int LANES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             chroma_format,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*PIX_W-1:0] in_y,
    input  logic [LANES*PIX_W-1:0] in_osd,
    input  logic [LANES*PIX_W-1:0] in_u_upper,
    input  logic [LANES*PIX_W-1:0] in_u_lower,
    input  logic [LANES*PIX_W-1:0] in_v_upper,
    input  logic [LANES*PIX_W-1:0] in_v_lower,
    input  logic [1:0]             in_vphase,
    input  logic [2:0]             in_position,
    input  logic                   pixel_wr_almost_full,
    output logic [PIX_W-1:0]       y,
    output logic [PIX_W-1:0]       u,
    output logic [PIX_W-1:0]       v,
    output logic [PIX_W-1:0]       osd_out,
    output logic [2:0]             position_out,
    output logic                   pixel_wr_en,
    output logic                   busy,
    output logic [1:0]             state_dbg
);

    localparam int             LW        = $clog2(LANES);
    localparam logic [LW-1:0]  LAST_LANE = LW'(LANES - 1);

    ups_state_t             state_q, state_d;
    logic [LW-1:0]          lane_q;
    logic                   ready_en_q;

    logic [1:0]             fmt_q;
    logic [1:0]             vph_q;
    logic [2:0]             pos_q;
    logic [LANES*PIX_W-1:0] y_q, osd_q, uu_q, ul_q, vu_q, vl_q;

    logic [LANES*PIX_W-1:0] u_c, v_c;
    logic [LANES*PIX_W-1:0] u_q, v_q;

    logic [PIX_W-1:0]       last_y_q, last_u_q, last_v_q, last_osd_q;
    logic [2:0]             last_pos_q;

    logic                   accept;
    logic                   last_lane;
    logic                   emit;
    logic [PIX_W-1:0]       cur_y, cur_u, cur_v, cur_osd;

    assign last_lane = (lane_q == LAST_LANE);
    assign emit      = (state_q == ST_SHIFT) && !pixel_wr_almost_full;
    // ready_en_q keeps in_ready low during reset and releases it one clock later.
    assign in_ready  = ready_en_q &&
                       ((state_q == ST_IDLE) ||
                        ((state_q == ST_SHIFT) && last_lane && !pixel_wr_almost_full));
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

    resample_lane_interp #(
        .PIX_W (PIX_W),
        .LANES (LANES)
    ) u_interp (
        .fmt     (fmt_q),
        .vphase  (vph_q),
        .u_upper (uu_q),
        .u_lower (ul_q),
        .v_upper (vu_q),
        .v_lower (vl_q),
        .u_out   (u_c),
        .v_out   (v_c)
    );

    // Next-state: one blend cycle per beat, then shift lanes until the last one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_BLEND;
            ST_BLEND: state_d = ST_SHIFT;
            ST_SHIFT: if (emit && last_lane) state_d = accept ? ST_BLEND : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register, lane counter and post-reset ready enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            lane_q     <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            if (emit) lane_q <= last_lane ? '0 : lane_q + LW'(1);
        end
    end

    // Capture the raw beat and its sideband fields on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fmt_q <= '0;
            vph_q <= '0;
            pos_q <= '0;
            y_q   <= '0;
            osd_q <= '0;
            uu_q  <= '0;
            ul_q  <= '0;
            vu_q  <= '0;
            vl_q  <= '0;
        end else if (accept) begin
            fmt_q <= chroma_format;
            vph_q <= in_vphase;
            pos_q <= in_position;
            y_q   <= in_y;
            osd_q <= in_osd;
            uu_q  <= in_u_upper;
            ul_q  <= in_u_lower;
            vu_q  <= in_v_upper;
            vl_q  <= in_v_lower;
        end
    end

    // Register the interpolated chroma during the blend cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            u_q <= '0;
            v_q <= '0;
        end else if (state_q == ST_BLEND) begin
            u_q <= u_c;
            v_q <= v_c;
        end
    end

    // Remember the last emitted pixel so outputs hold while stalled or idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_y_q   <= '0;
            last_u_q   <= '0;
            last_v_q   <= '0;
            last_osd_q <= '0;
            last_pos_q <= POS_INTERIOR;
        end else if (emit) begin
            last_y_q   <= cur_y;
            last_u_q   <= cur_u;
            last_v_q   <= cur_v;
            last_osd_q <= cur_osd;
            last_pos_q <= pos_q;
        end
    end

    // Lane select and output mux: live lane while emitting, otherwise the held pixel.
    always_comb begin
        cur_y        = y_q[int'(lane_q)*PIX_W +: PIX_W];
        cur_u        = u_q[int'(lane_q)*PIX_W +: PIX_W];
        cur_v        = v_q[int'(lane_q)*PIX_W +: PIX_W];
        cur_osd      = osd_q[int'(lane_q)*PIX_W +: PIX_W];
        pixel_wr_en  = emit;
        y            = emit ? cur_y   : last_y_q;
        u            = emit ? cur_u   : last_u_q;
        v            = emit ? cur_v   : last_v_q;
        osd_out      = emit ? cur_osd : last_osd_q;
        position_out = emit ? pos_q   : last_pos_q;
    end

endmodule
